ctrl_pipeline: RTL

Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage instruction into a packed control bundle and carries the bundle through the EX, MEM and WB registers. It also owns all hazard and sequencing decisions: load-use stalls, multi-cycle multiply/divide occupancy, branch/jump squashing and interrupt entry. It sits beside the IF/ID register and drives the PC, IF/ID and stage-register enables.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decode.sv | 53 +++++
 rtl/ctrl_pipeline.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants for the pipelined MIPS control unit
package ctrl_pkg;

  localparam int CTRL_W = 21;

  // Control bundle field offsets, LSB first; bit 20 is reserved and always 0
  localparam int F_PCSRC    = 0;
  localparam int F_BRANCH   = 2;
  localparam int F_REGWRITE = 3;
  localparam int F_REGDST   = 4;
  localparam int F_MEMREAD  = 6;
  localparam int F_MEMWRITE = 7;
  localparam int F_MEMTOREG = 8;
  localparam int F_ALUSRC1  = 10;
  localparam int F_ALUSRC2  = 11;
  localparam int F_EXTOP    = 12;
  localparam int F_LUOP     = 13;
  localparam int F_ALUOP    = 14;
  localparam int F_MD       = 18;
  localparam int F_ILLEGAL  = 19;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_EXC     = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] PC_EXC  = 2'b11;

  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct to control bundle decoder
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl
);

  logic       is_r, is_jr, is_jalr, is_md, is_shift, is_imm, is_lw, is_sw, is_lui, is_jal, known;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_base;
  logic       reg_write;

  assign is_r     = (opcode == OP_RTYPE);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_jalr  = is_r && (funct == FN_JALR);
  assign is_md    = is_r && ((funct == FN_MULT) || (funct == FN_DIV));
  assign is_shift = is_r && ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
  assign is_imm   = opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI};
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_lui   = (opcode == OP_LUI);
  assign is_jal   = (opcode == OP_JAL);
  assign known    = is_r || is_imm || is_lw || is_sw || is_lui || is_jal ||
                    (opcode == OP_BEQ) || (opcode == OP_J);

  assign pc_src     = (opcode == OP_J || is_jal) ? PC_JUMP : ((is_jr || is_jalr) ? PC_REG : PC_SEQ);
  assign reg_dst    = is_jal ? 2'b10 : (is_r ? 2'b01 : 2'b00);
  assign mem_to_reg = is_lw ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
  assign reg_write  = (is_r && !is_jr && !is_md) || is_lw || is_lui || is_imm || is_jal;

  always_comb begin
    alu_base = 3'b000;
    if (is_r)                                        alu_base = 3'b010;
    else if (opcode == OP_BEQ)                       alu_base = 3'b001;
    else if (opcode == OP_ANDI)                      alu_base = 3'b100;
    else if (opcode == OP_SLTI || opcode == OP_SLTIU) alu_base = 3'b101;
  end

  // Unknown opcodes carry only the Illegal flag so nothing downstream writes state
  always_comb begin
    ctrl = '0;
    if (known) begin
      ctrl = {1'b0, 1'b0, is_md, {opcode[0], alu_base}, is_lui, (opcode != OP_ANDI),
              (is_imm || is_lw || is_sw || is_lui), is_shift, mem_to_reg, is_sw, is_lw,
              reg_dst, reg_write, (opcode == OP_BEQ), pc_src};
    end else begin
      ctrl[F_ILLEGAL] = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - decode, stage control registers and hazard/sequencing FSM
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int IRQ_EN     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              br_taken,
  input  logic              irq,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_rt,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        pc_src,
  output logic              md_busy,
  output logic              irq_ack
);

  localparam logic [4:0] MD_LOAD  = 5'(MD_LATENCY - 1);
  localparam logic       MD_MULTI = (MD_LATENCY > 1);

  typedef enum logic [1:0] {EX_LOAD, EX_BUBBLE, EX_HOLD} ex_sel_t;

  logic [CTRL_W-1:0] dec;
  state_t            state, next_state;
  logic [4:0]        cnt, next_cnt;
  logic              load_use, exc_req, md_release, md_hold, mem_bubble;
  ex_sel_t           ex_sel;

  ctrl_decode u_decode (
    .opcode (id_opcode),
    .funct  (id_funct),
    .ctrl   (dec)
  );

  assign load_use = ex_ctrl[F_MEMREAD] && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt(id_opcode) && (ex_rt == id_rt)));
  assign exc_req  = (irq && (IRQ_EN != 0)) || dec[F_ILLEGAL];

  // The mult sits in EX for one RUN cycle plus MD_LATENCY-1 wait cycles; the last
  // wait cycle releases EX and is then decided like an ordinary RUN cycle.
  assign md_release = (state == ST_MD_WAIT) && (cnt <= 5'd1);
  assign md_hold    = ((state == ST_RUN) && ex_ctrl[F_MD] && MD_MULTI) ||
                      ((state == ST_MD_WAIT) && !md_release);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= 5'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = ST_RUN;
    next_cnt   = 5'd0;
    case (state)
      ST_RUN: begin
        if (md_hold) begin
          next_state = ST_MD_WAIT;
          next_cnt   = MD_LOAD;
        end else if (!br_taken && exc_req) begin
          next_state = ST_EXC;
        end
      end
      ST_MD_WAIT: begin
        if (md_hold) begin
          next_state = ST_MD_WAIT;
          next_cnt   = cnt - 5'd1;
        end else if (!br_taken && exc_req) begin
          next_state = ST_EXC;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = PC_SEQ;
    ex_sel     = EX_LOAD;
    mem_bubble = 1'b0;
    if (state == ST_EXC) begin
      ifid_flush = 1'b1;
      pc_src     = PC_EXC;
      ex_sel     = EX_BUBBLE;
    end else if (md_hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_sel     = EX_HOLD;
      mem_bubble = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      ex_sel     = EX_BUBBLE;
    end else if (exc_req || load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_sel     = EX_BUBBLE;
    end else begin
      pc_src     = dec[F_PCSRC +: 2];
      ifid_flush = (dec[F_PCSRC +: 2] != PC_SEQ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl  <= '0;
      ex_rt    <= 5'd0;
      mem_ctrl <= '0;
      wb_ctrl  <= '0;
    end else begin
      case (ex_sel)
        EX_LOAD: begin
          ex_ctrl <= dec;
          ex_rt   <= id_rt;
        end
        EX_BUBBLE: begin
          ex_ctrl <= '0;
          ex_rt   <= 5'd0;
        end
        default: begin
          ex_ctrl <= ex_ctrl;
          ex_rt   <= ex_rt;
        end
      endcase
      mem_ctrl <= mem_bubble ? '0 : ex_ctrl;
      wb_ctrl  <= mem_ctrl;
    end
  end

  assign md_busy = (state == ST_MD_WAIT);
  assign irq_ack = (state == ST_EXC) && (IRQ_EN != 0);

endmodule
